// File: rtl/hazard_ctrl_mc.sv
// Pipeline hazard controller: memory freeze with timeout, branch flush, mul/div interlock and
// load-use bubble. Optional statistics counters are built when HZ_STATS_EN is defined.
module hazard_ctrl_mc #(
    parameter int unsigned REG_W    = 5,
    parameter int unsigned MD_LAT   = 32,
    parameter int unsigned MD_CNT_W = 6,
    parameter int unsigned MEM_TMO  = 255,
    parameter int unsigned STAT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_W-1:0]  if2idRs,
    input  logic [REG_W-1:0]  if2idRt,
    input  logic [REG_W-1:0]  id2exRt,
    input  logic              id2ex_MemRead,
    input  logic              id_md_use,
    input  logic              ex_md_start,
    input  logic              ex_branch_tkn,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              PCWrite,
    output logic              IF2IDWrite,
    output logic              con_mux,
    output logic              IF2IDFlush,
    output logic              ID2EXWrite,
    output logic              EX2MEMWrite,
    output logic              MEM2WBValid,
    output logic              md_busy,
    output logic              mem_err,
    output logic [STAT_W-1:0] stall_cycles,
    output logic [STAT_W-1:0] flush_count
);

    localparam int unsigned TMO_W = (MEM_TMO < 1) ? 1 : $clog2(MEM_TMO + 1);

    typedef enum logic {StRun, StMemWait} state_e;

    state_e              state_q, state_d;
    logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic                mem_err_q, mem_err_d;

    logic freeze, load_use, md_stall;

    assign freeze   = mem_req && !mem_ready;
    assign md_busy  = (md_cnt_q != '0);
    assign md_stall = id_md_use && md_busy;
    assign load_use = id2ex_MemRead && (id2exRt != '0) &&
                      ((if2idRs == id2exRt) || (if2idRt == id2exRt));
    assign mem_err  = mem_err_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StRun;
            md_cnt_q  <= '0;
            tmo_cnt_q <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            md_cnt_q  <= md_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = '0;
        mem_err_d = mem_err_q;
        md_cnt_d  = md_cnt_q;

        unique case (state_q)
            StRun: begin
                if (freeze) begin
                    state_d = StMemWait;
                end
            end
            StMemWait: begin
                if (!freeze) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase

        // tmo_cnt holds the number of wait cycles already spent; saturates at the limit
        if (freeze) begin
            if (tmo_cnt_q == TMO_W'(MEM_TMO)) begin
                tmo_cnt_d = tmo_cnt_q;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
            if ((state_q == StMemWait) && (tmo_cnt_q == TMO_W'(MEM_TMO))) begin
                mem_err_d = 1'b1;
            end
        end

        // The mul/div unit keeps counting through a freeze; only new issues are blocked
        if (ex_md_start && !freeze) begin
            md_cnt_d = MD_CNT_W'(MD_LAT);
        end else if (md_busy) begin
            md_cnt_d = md_cnt_q - 1'b1;
        end
    end

    // Output logic
    always_comb begin
        PCWrite     = 1'b1;
        IF2IDWrite  = 1'b1;
        con_mux     = 1'b1;
        IF2IDFlush  = 1'b0;
        ID2EXWrite  = 1'b1;
        EX2MEMWrite = 1'b1;
        MEM2WBValid = 1'b1;

        if (!rst) begin
            if (freeze) begin
                PCWrite     = 1'b0;
                IF2IDWrite  = 1'b0;
                ID2EXWrite  = 1'b0;
                EX2MEMWrite = 1'b0;
                MEM2WBValid = 1'b0;
            end else if (ex_branch_tkn) begin
                IF2IDFlush = 1'b1;
                con_mux    = 1'b0;
            end else if (md_stall || load_use) begin
                PCWrite    = 1'b0;
                IF2IDWrite = 1'b0;
                con_mux    = 1'b0;
            end
        end
    end

`ifdef HZ_STATS_EN
    logic [STAT_W-1:0] stall_q, stall_d;
    logic [STAT_W-1:0] flush_q, flush_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!PCWrite) begin
            stall_d = stall_q + 1'b1;
        end
        if (IF2IDFlush) begin
            flush_d = flush_q + 1'b1;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Scoreboard bench for hazard_ctrl_mc: a cycle-level reference model pushes expected outputs,
// a monitor on the falling edge pops and compares them against the DUT.
module tb_hazard_ctrl_mc;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned MD_LAT  = 32;
    localparam int unsigned MEM_TMO = 255;
    localparam int unsigned STAT_W  = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [REG_W-1:0] if2idRs, if2idRt, id2exRt;
    logic             id2ex_MemRead, id_md_use, ex_md_start, ex_branch_tkn, mem_req, mem_ready;
    logic             PCWrite, IF2IDWrite, con_mux, IF2IDFlush, ID2EXWrite, EX2MEMWrite;
    logic             MEM2WBValid, md_busy, mem_err;
    logic [STAT_W-1:0] stall_cycles, flush_count;

    always #5 clk = ~clk;

    hazard_ctrl_mc #(
        .REG_W   (REG_W),
        .MD_LAT  (MD_LAT),
        .MD_CNT_W(6),
        .MEM_TMO (MEM_TMO),
        .STAT_W  (STAT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .if2idRs      (if2idRs),
        .if2idRt      (if2idRt),
        .id2exRt      (id2exRt),
        .id2ex_MemRead(id2ex_MemRead),
        .id_md_use    (id_md_use),
        .ex_md_start  (ex_md_start),
        .ex_branch_tkn(ex_branch_tkn),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .PCWrite      (PCWrite),
        .IF2IDWrite   (IF2IDWrite),
        .con_mux      (con_mux),
        .IF2IDFlush   (IF2IDFlush),
        .ID2EXWrite   (ID2EXWrite),
        .EX2MEMWrite  (EX2MEMWrite),
        .MEM2WBValid  (MEM2WBValid),
        .md_busy      (md_busy),
        .mem_err      (mem_err),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    typedef struct {
        logic        pc, ifw, cmux, flush, idex, exmem, memwb, busy, err;
        logic [31:0] stalls, flushes;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int          md_left   = 0;
    int          wait_run  = 0;
    bit          err_flag  = 1'b0;
    logic [31:0] n_stall   = '0;
    logic [31:0] n_flush   = '0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Apply one cycle of inputs and queue the outputs the block should show this cycle
    task automatic cycle(input logic r, input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                         input logic [REG_W-1:0] ert, input logic mrd, input logic mduse,
                         input logic mdst, input logic br, input logic req, input logic rdy);
        exp_t e;
        bit   frz, lu, stall;
        @(posedge clk);
        #1;
        rst = r; if2idRs = rs; if2idRt = rt; id2exRt = ert; id2ex_MemRead = mrd;
        id_md_use = mduse; ex_md_start = mdst; ex_branch_tkn = br; mem_req = req;
        mem_ready = rdy;

        frz = req && !rdy;
        lu  = mrd && (ert != 0) && (rs == ert || rt == ert);
        e.pc = 1; e.ifw = 1; e.cmux = 1; e.flush = 0; e.idex = 1; e.exmem = 1; e.memwb = 1;
        if (!r) begin
            if (frz) begin
                e.pc = 0; e.ifw = 0; e.idex = 0; e.exmem = 0; e.memwb = 0;
            end else if (br) begin
                e.flush = 1; e.cmux = 0;
            end else if ((mduse && md_left > 0) || lu) begin
                e.pc = 0; e.ifw = 0; e.cmux = 0;
            end
        end
        e.busy = (md_left > 0);
        e.err  = err_flag;
`ifdef HZ_STATS_EN
        e.stalls  = n_stall;
        e.flushes = n_flush;
`else
        e.stalls  = '0;
        e.flushes = '0;
`endif
        exp_q.push_back(e);

        stall = !e.pc;
        if (r) begin
            md_left = 0; wait_run = 0; err_flag = 0; n_stall = '0; n_flush = '0;
        end else begin
            if (mdst && !frz) md_left = MD_LAT;
            else if (md_left > 0) md_left--;
            if (frz && wait_run >= MEM_TMO) err_flag = 1;
            wait_run = frz ? wait_run + 1 : 0;
            if (stall) n_stall = n_stall + 1;
            if (e.flush) n_flush = n_flush + 1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("PCWrite",      32'(PCWrite),     32'(e.pc));
                cmp("IF2IDWrite",   32'(IF2IDWrite),  32'(e.ifw));
                cmp("con_mux",      32'(con_mux),     32'(e.cmux));
                cmp("IF2IDFlush",   32'(IF2IDFlush),  32'(e.flush));
                cmp("ID2EXWrite",   32'(ID2EXWrite),  32'(e.idex));
                cmp("EX2MEMWrite",  32'(EX2MEMWrite), 32'(e.exmem));
                cmp("MEM2WBValid",  32'(MEM2WBValid), 32'(e.memwb));
                cmp("md_busy",      32'(md_busy),     32'(e.busy));
                cmp("mem_err",      32'(mem_err),     32'(e.err));
                cmp("stall_cycles", stall_cycles,     e.stalls);
                cmp("flush_count",  flush_count,      e.flushes);
            end
        end
    end

    // Stimulus
    initial begin
        rst = 1; if2idRs = 0; if2idRt = 0; id2exRt = 0; id2ex_MemRead = 0; id_md_use = 0;
        ex_md_start = 0; ex_branch_tkn = 0; mem_req = 0; mem_ready = 0;
        // Unscored reset cycle brings registered outputs out of X
        @(posedge clk);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Load-use: match on rs, match on rt, destination r0, no load
        cycle(0, 8, 1, 8, 1, 0, 0, 0, 0, 0);
        cycle(0, 3, 9, 9, 1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        cycle(0, 8, 8, 8, 0, 0, 0, 0, 0, 0);
        idle(1);

        // Mul/div interlock with consumer held waiting
        cycle(0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 34; i++) cycle(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        // Three freeze cycles, then memory completes
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(1);

        // Branch beats load-use; freeze beats branch; md start blocked by freeze
        cycle(0, 5, 0, 5, 1, 0, 0, 1, 0, 0);
        cycle(0, 5, 0, 5, 1, 0, 0, 1, 1, 0);
        cycle(0, 0, 0, 0, 0, 1, 1, 0, 1, 0);
        idle(2);

        // Timeout: 260 wait cycles, error stays after memory recovers, reset clears it
        for (int i = 0; i < 260; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(4);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Reset in the middle of a mul/div stall
        cycle(0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        // Random traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom_range(0, 299) == 0),
                  REG_W'($urandom_range(0, 3)), REG_W'($urandom_range(0, 3)),
                  REG_W'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 3),
                  1'($urandom_range(0, 1)));
        end
        idle(2);

        @(negedge clk);
        #1;
        cmp("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
